// File: rtl/hazard_pkg.sv
// Shared definitions for the pipeline hazard unit: forward-select encodings,
// nominal unit latencies and the hazard-cause bundle.
//
// Contents:
//   fwd_sel_e  : E-stage operand source (register file, W stage, M stage)
//   LAT_*      : nominal result latencies, counted from E entry
//   hz_cause_t : the three independent reasons for holding D
package hazard_pkg;

    typedef enum logic [1:0] {
        FWD_RF = 2'b00,
        FWD_W  = 2'b01,
        FWD_M  = 2'b10
    } fwd_sel_e;

    localparam int unsigned LAT_ALU  = 1;
    localparam int unsigned LAT_LOAD = 2;
    localparam int unsigned LAT_MUL  = 4;

    typedef struct packed {
        logic raw;
        logic waw;
        logic busy;
    } hz_cause_t;

endpackage

// File: rtl/fwd_sel.sv
// Forwarding source select for one E-stage operand.
// The youngest producer (M) wins over the older one (W); x0 never forwards.
//
// Ports:
//   src_i         : E-stage source register address
//   rd_m_i        : M-stage destination
//   reg_write_m_i : M-stage write enable
//   rd_w_i        : W-stage destination
//   reg_write_w_i : W-stage write enable
//   fwd_o         : 00 register file, 01 W stage, 10 M stage
module fwd_sel
    import hazard_pkg::*;
#(
    parameter int REG_AW = 5
)(
    input  logic [REG_AW-1:0] src_i,
    input  logic [REG_AW-1:0] rd_m_i,
    input  logic              reg_write_m_i,
    input  logic [REG_AW-1:0] rd_w_i,
    input  logic              reg_write_w_i,
    output logic [1:0]        fwd_o
);

    logic src_nz;
    logic m_hit;
    logic w_hit;

    assign src_nz = (src_i != '0);
    assign m_hit  = reg_write_m_i && (rd_m_i == src_i) && src_nz;
    assign w_hit  = reg_write_w_i && (rd_w_i == src_i) && src_nz;

    always_comb begin
        fwd_o = FWD_RF;
        if (m_hit) begin
            fwd_o = FWD_M;
        end else if (w_hit) begin
            fwd_o = FWD_W;
        end
    end

endmodule

// File: rtl/hazard_scoreboard.sv
// Pipeline hazard unit built on a per-register pending-latency scoreboard.
// Produces F/D stall, D/E and F/D flush, and E-stage forwarding selects.
//
// Ports:
//   clk, rst             : clock, asynchronous active-low reset
//   issue_d              : valid instruction in D
//   rs1_d/rs2_d          : D-stage sources, qualified by rs1_used_d/rs2_used_d
//   rd_d, reg_write_d    : D-stage destination and write enable
//   lat_d                : cycles from E entry to forwardable result (0 -> 1)
//   rs1_e/rs2_e          : E-stage sources for forwarding
//   pc_src_e             : redirect resolved in E
//   rd_m/reg_write_m     : M-stage destination
//   rd_w/reg_write_w     : W-stage destination
//   stall_f/stall_d      : hold PC and F/D register
//   flush_d/flush_e      : clear F/D and D/E registers
//   forward_a_e/_b_e     : operand source selects
//   pending              : per-register "counter non-zero" flags
module hazard_scoreboard
    import hazard_pkg::*;
#(
    parameter int NUM_REGS = 32,
    parameter int REG_AW   = 5,
    parameter int LAT_W    = 3,
    parameter int LONG_LAT = 3
)(
    input  logic                clk,
    input  logic                rst,
    input  logic                issue_d,
    input  logic [REG_AW-1:0]   rs1_d,
    input  logic [REG_AW-1:0]   rs2_d,
    input  logic                rs1_used_d,
    input  logic                rs2_used_d,
    input  logic [REG_AW-1:0]   rd_d,
    input  logic                reg_write_d,
    input  logic [LAT_W-1:0]    lat_d,
    input  logic [REG_AW-1:0]   rs1_e,
    input  logic [REG_AW-1:0]   rs2_e,
    input  logic                pc_src_e,
    input  logic [REG_AW-1:0]   rd_m,
    input  logic                reg_write_m,
    input  logic [REG_AW-1:0]   rd_w,
    input  logic                reg_write_w,
    output logic                stall_f,
    output logic                stall_d,
    output logic                flush_d,
    output logic                flush_e,
    output logic [1:0]          forward_a_e,
    output logic [1:0]          forward_b_e,
    output logic [NUM_REGS-1:0] pending
);

    localparam logic [LAT_W-1:0] ONE  = LAT_W'(1);
    localparam logic [LAT_W-1:0] MIN  = LAT_W'(LAT_ALU);
    localparam logic [LAT_W-1:0] LONG = LAT_W'(LONG_LAT);

    logic [NUM_REGS-1:0][LAT_W-1:0] cnt_q;
    logic [NUM_REGS-1:0][LAT_W-1:0] cnt_d;
    logic [LAT_W-1:0]               unit_cnt_q;
    logic [LAT_W-1:0]               unit_cnt_d;

    logic [LAT_W-1:0] eff_lat;
    logic             long_op;
    logic             rd_valid;
    logic             src1_busy;
    logic             src2_busy;
    hz_cause_t        cause;
    logic             hz;
    logic             fire;

    // A latency of zero would never protect its consumer, so treat it as ALU.
    assign eff_lat  = (lat_d == '0) ? MIN : lat_d;
    assign long_op  = (eff_lat >= LONG);
    assign rd_valid = reg_write_d && (rd_d != '0);

    // A count of 1 means the result is forwardable next cycle, so only
    // counts above 1 block a reader.
    assign src1_busy = rs1_used_d && (cnt_q[rs1_d] > ONE);
    assign src2_busy = rs2_used_d && (cnt_q[rs2_d] > ONE);

    always_comb begin
        cause      = '0;
        cause.raw  = issue_d && (src1_busy || src2_busy);
        // An older write finishing after this one would clobber it.
        cause.waw  = issue_d && rd_valid && (cnt_q[rd_d] > eff_lat);
        // The long-latency unit is not pipelined.
        cause.busy = issue_d && long_op && (unit_cnt_q > ONE);
    end

    assign hz   = |cause;
    assign fire = issue_d && !hz && !pc_src_e;

    // A redirect kills the D instruction, so holding it would be pointless.
    assign stall_f = hz && !pc_src_e;
    assign stall_d = hz && !pc_src_e;
    assign flush_d = pc_src_e;
    assign flush_e = hz || pc_src_e;

    always_comb begin
        cnt_d = cnt_q;
        for (int r = 0; r < NUM_REGS; r++) begin
            if (r == 0) begin
                cnt_d[r] = '0;
            end else if (fire && rd_valid && (rd_d == REG_AW'(r))) begin
                cnt_d[r] = eff_lat;
            end else if (cnt_q[r] != '0) begin
                cnt_d[r] = cnt_q[r] - ONE;
            end
        end
    end

    always_comb begin
        unit_cnt_d = unit_cnt_q;
        if (fire && long_op) begin
            unit_cnt_d = eff_lat;
        end else if (unit_cnt_q != '0) begin
            unit_cnt_d = unit_cnt_q - ONE;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q      <= '0;
            unit_cnt_q <= '0;
        end else begin
            cnt_q      <= cnt_d;
            unit_cnt_q <= unit_cnt_d;
        end
    end

    always_comb begin
        pending = '0;
        for (int r = 0; r < NUM_REGS; r++) begin
            pending[r] = (cnt_q[r] != '0);
        end
    end

    fwd_sel #(
        .REG_AW(REG_AW)
    ) u_fwd_a (
        .src_i        (rs1_e),
        .rd_m_i       (rd_m),
        .reg_write_m_i(reg_write_m),
        .rd_w_i       (rd_w),
        .reg_write_w_i(reg_write_w),
        .fwd_o        (forward_a_e)
    );

    fwd_sel #(
        .REG_AW(REG_AW)
    ) u_fwd_b (
        .src_i        (rs2_e),
        .rd_m_i       (rd_m),
        .reg_write_m_i(reg_write_m),
        .rd_w_i       (rd_w),
        .reg_write_w_i(reg_write_w),
        .fwd_o        (forward_b_e)
    );

endmodule

// File: doc/hazard_scoreboard.md
Name: hazard_scoreboard

Overview:
Parametrised hazard unit for the 5-stage pipeline. It replaces fixed load-use detection with a per-register pending-latency scoreboard, so the pipeline can mix ALU, load and variable-latency units such as a future mul/div. It produces the F/D stall, D/E flush and E-stage forwarding selects. It sits beside the pipeline registers in the cpu top and is driven from the D, E, M and W stages.

Parameters:
NUM_REGS, 32, architectural registers; x0 is never tracked
REG_AW, 5, register address width, equal to clog2(NUM_REGS)
LAT_W, 3, width of the latency field and counters; max latency 2^LAT_W-1
LONG_LAT, 3, latency at or above which an op uses the shared non-pipelined unit

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  asynchronous reset, active-low
issue_d  in  1  valid instruction in D, candidate to advance to E
rs1_d  in  REG_AW  D-stage source 1
rs2_d  in  REG_AW  D-stage source 2
rs1_used_d  in  1  rs1 is read by the D instruction
rs2_used_d  in  1  rs2 is read by the D instruction
rd_d  in  REG_AW  D-stage destination
reg_write_d  in  1  D instruction writes rd_d
lat_d  in  LAT_W  cycles from E entry until result is forwardable; 1=ALU, 2=load, 3+=long op; 0 is treated as 1
rs1_e  in  REG_AW  E-stage source 1
rs2_e  in  REG_AW  E-stage source 2
pc_src_e  in  1  taken branch or jump resolved in E
rd_m  in  REG_AW  M-stage destination
reg_write_m  in  1  M-stage write enable
rd_w  in  REG_AW  W-stage destination
reg_write_w  in  1  W-stage write enable
stall_f  out  1  hold PC
stall_d  out  1  hold F/D register
flush_d  out  1  clear F/D register
flush_e  out  1  clear D/E register (insert bubble)
forward_a_e  out  2  00 regfile, 01 from W, 10 from M
forward_b_e  out  2  same encoding for source 2
pending  out  NUM_REGS  bit r = 1 when cnt[r] != 0 (debug/verification)

Behaviour:
- State: cnt[r] (LAT_W bits) for r = 1..NUM_REGS-1, plus unit_cnt (LAT_W bits). cnt[0] is hard-wired 0.
- Reset: rst=0 clears all cnt and unit_cnt asynchronously. Under reset stall_f=stall_d=0, pending=0. Flush and forward outputs stay pure combinational functions of their inputs.
- raw = issue_d & ((rs1_used_d & cnt[rs1_d]>1) | (rs2_used_d & cnt[rs2_d]>1)).
- waw = issue_d & reg_write_d & rd_d!=0 & cnt[rd_d] > eff_lat, where eff_lat = max(lat_d, 1). This keeps writes in order.
- struct = issue_d & eff_lat>=LONG_LAT & unit_cnt>1.
- hz = raw | waw | struct.
- Outputs: stall_f = stall_d = hz & ~pc_src_e; flush_d = pc_src_e; flush_e = hz | pc_src_e.
- Issue fires when issue_d & ~hz & ~pc_src_e.
- Next-state per register, every cycle:
  - If issue fires and reg_write_d & rd_d==r & r!=0: cnt[r] <= eff_lat. Set wins over decrement.
  - Else if cnt[r]!=0: cnt[r] <= cnt[r]-1.
- unit_cnt follows the same rule: it loads eff_lat when a firing op has eff_lat>=LONG_LAT, otherwise it decrements to 0.
- Counters saturate at 0 and never wrap.
- A flushed, stalled or non-issuing D instruction never touches the scoreboard. A long op already in E/M keeps counting through a branch flush.
- Latency: a consumer issued in cycle t+k, producer issued in cycle t, is released when cnt<=1. Load-use costs 1 stall; an op with latency L costs L-1 stalls.
- Forwarding, per source s in {rs1_e, rs2_e}:
  - 10 if reg_write_m & rd_m==s & s!=0;
  - else 01 if reg_write_w & rd_w==s & s!=0;
  - else 00.
  - M has priority over W.
- Simultaneous pc_src_e and hz: the flush dominates, stall is deasserted and the PC redirects.

Decomposition:
- Shared package hazard_pkg holds:
  - FWD_RF=2'b00, FWD_W=2'b01, FWD_M=2'b10;
  - LAT_ALU=1, LAT_LOAD=2, LAT_MUL=4.
- One sub-module, fwd_sel: combinational forward select, instantiated twice (source a and source b).
- The scoreboard counters stay inline in hazard_scoreboard.

Test Plan:
- ALU producer then dependent: issue rd=5 lat=1, next cycle rs1_d=5 used -> no stall; next cycle forward_a_e=10, the cycle after 00 unless W matches.
- Load-use: issue rd=7 lat=2, then rs2_d=7 used -> stall_f=stall_d=flush_e=1 for exactly 1 cycle, then forward_b_e=01 (W) or 10 per pipeline position.
- Long op: issue rd=3 lat=4 -> a dependent stalls 3 cycles. A second lat=4 op issued 1 cycle after the first stalls 3 cycles on struct. pending[3] clears after 4 cycles.
- WAW: lat=4 to rd=9, then ALU write rd=9 lat=1 -> stall until cnt[9]<=1, then issue, and cnt[9] reloads to 1.
- Branch during stall: load-use stall active and pc_src_e=1 -> stall_f=0, flush_d=flush_e=1, scoreboard for the D instruction untouched; rd_d=0 issue never sets pending.
- Async reset mid-operation: cnt[3]=3, drop rst between edges -> pending=0 and stall=0 immediately; after release, a dependent on x3 issues with no stall.
